lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 134 +++++++++++++
 tb/tb_lsu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RISC-V funct3 width codes, FSM states, lane-offset width helper.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;

  function automatic int lsu_offw(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/mask shift and load shift + sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = lsu_offw(XLEN)
) (
  input  logic [2:0]      i_funct3,
  input  logic [OFFW-1:0] i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_wmask,
  output logic [XLEN-1:0] o_rdata
);

  logic [OFFW+2:0] w_sh;
  logic [3:0]      w_nb;
  logic [XLEN-1:0] w_szmask;
  logic [XLEN-1:0] w_shr;
  logic            w_msb;

  assign w_sh = {i_off, 3'b000};
  assign w_nb = 4'd1 << i_funct3[1:0];

  // Right-justified mask covering the access width in bits.
  always_comb begin
    w_szmask = '0;
    for (int b = 0; b < XLEN / 8; b++)
      w_szmask[8*b +: 8] = (b < int'(w_nb)) ? 8'hff : 8'h00;
  end

  assign w_shr = i_rdata >> w_sh;

  always_comb begin
    w_msb = 1'b0;
    unique case (i_funct3[1:0])
      2'd0:    w_msb = w_shr[7];
      2'd1:    w_msb = w_shr[15];
      2'd2:    w_msb = w_shr[31];
      default: w_msb = w_shr[XLEN-1];
    endcase
  end

  assign o_wmask = w_szmask << w_sh;
  assign o_wdata = (i_wdata & w_szmask) << w_sh;
  // funct3[2] marks the unsigned load variants.
  assign o_rdata = (w_shr & w_szmask) | ((w_msb && !i_funct3[2]) ? ~w_szmask : '0);

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between core and a word-wide memory port.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [XLEN-1:0] o_mem_wmask,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int OFFW = lsu_offw(XLEN);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam bit IS64 = (XLEN == 64);

  lsu_state_e      r_state, w_state_nxt;
  logic            r_we, r_err;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_f3_ok, w_legal, w_tmo;
  logic [OFFW-1:0] w_amask;
  logic [XLEN-1:0] w_eaddr;
  logic [XLEN-1:0] w_al_wdata, w_al_wmask, w_al_rdata;

  always_comb begin
    w_f3_ok = 1'b0;
    if (i_req_we)
      w_f3_ok = !i_req_funct3[2] && (i_req_funct3[1:0] != 2'd3 || IS64);
    else
      w_f3_ok = (i_req_funct3 != 3'b111) &&
                ((i_req_funct3 != F3_LD && i_req_funct3 != F3_LWU) || IS64);
  end

  // Offset bits that must be zero for a naturally aligned access of this size.
  assign w_amask = OFFW'((4'd1 << i_req_funct3[1:0]) - 4'd1);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis   = |(i_req_addr[OFFW-1:0] & w_amask);
  assign w_legal = w_f3_ok && !w_mis;
  assign w_eaddr = i_req_addr;
`else
  assign w_legal = w_f3_ok;
  assign w_eaddr = {i_req_addr[XLEN-1:OFFW], i_req_addr[OFFW-1:0] & ~w_amask};
`endif

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_tmo     = (w_cnt_nxt == CW'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_req_valid) w_state_nxt = w_legal ? S_REQ : S_RESP;
      S_REQ:   if (i_mem_ready) w_state_nxt = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (i_mem_rvalid || w_tmo) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_we     <= i_req_we;
          r_funct3 <= i_req_funct3;
          r_addr   <= w_eaddr;
          r_wdata  <= i_req_wdata;
          r_err    <= !w_legal;
          r_rdata  <= '0;
        end
        S_REQ: r_cnt <= '0;
        // rvalid takes priority over a timeout landing in the same cycle.
        S_WAIT: begin
          if (i_mem_rvalid) r_rdata <= w_al_rdata;
          else if (w_tmo)   r_err   <= 1'b1;
          else              r_cnt   <= w_cnt_nxt;
        end
        default: ;
      endcase
    end
  end

  lsu_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[OFFW-1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (i_mem_rdata),
    .o_wdata  (w_al_wdata),
    .o_wmask  (w_al_wmask),
    .o_rdata  (w_al_rdata)
  );

  assign o_req_ready = (r_state == S_IDLE);
  assign o_mem_valid = (r_state == S_REQ);
  assign o_mem_we    = o_mem_valid && r_we;
  assign o_mem_addr  = o_mem_valid ? {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign o_mem_wdata = o_mem_we ? w_al_wdata : '0;
  assign o_mem_wmask = o_mem_we ? w_al_wmask : '0;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = o_rsp_valid ? r_rdata : '0;
  assign o_rsp_err   = o_rsp_valid && r_err;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu (XLEN=32, TIMEOUT=4); expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_mem_valid, i_mem_ready, o_mem_we, i_mem_rvalid;
  logic [31:0] o_mem_addr, o_mem_wdata, o_mem_wmask, i_mem_rdata;

  int n_tot = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Response monitor: every o_rsp_valid pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (o_rsp_valid) begin
      if (sb.size() == 0) chk("spurious_rsp", o_rsp_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, o_rsp_rdata, e.rd);
        chk({e.tag, "_err"}, o_rsp_err, e.err);
      end
    end
  end

  // e_lat: rising edges from acceptance to the edge that samples o_rsp_valid (0 = skip).
  // e_wait: cycles spent in WAIT before the response (-1 = skip).
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mword,
                        input bit give_rv, input logic [31:0] e_rd, input logic e_err,
                        input bit e_mem, input logic [31:0] e_maddr, input logic [31:0] e_mwd,
                        input logic [31:0] e_mwm, input int e_lat, input int e_wait);
    int cyc, hs;
    bit seen, rv_now, done;
    exp_t e;
    @(negedge clk);
    chk({tag, "_ready"}, o_req_ready, 1'b1);
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wd;
    e.rd = e_rd; e.err = e_err; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1 i_req_valid = 1'b0;
    cyc = 0; hs = -1; seen = 0; rv_now = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (o_rsp_valid) done = 1;
      else if (cyc >= 40) begin
        chk({tag, "_no_rsp"}, o_rsp_valid, 1'b1);
        done = 1;
      end else begin
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        if (rv_now) begin
          i_mem_rvalid = 1'b1; i_mem_rdata = mword; rv_now = 0;
        end
        if (o_mem_valid) begin
          if (!seen) begin
            chk({tag, "_maddr"}, o_mem_addr, e_maddr);
            chk({tag, "_mwe"}, o_mem_we, we);
            chk({tag, "_mwd"}, o_mem_wdata & o_mem_wmask, e_mwd);
            chk({tag, "_mwm"}, o_mem_wmask, e_mwm);
          end
          seen = 1; i_mem_ready = 1'b1; hs = cyc;
          rv_now = !we && give_rv;
        end
        @(posedge clk); cyc++;
      end
    end
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    chk({tag, "_memcmd"}, seen, e_mem);
    if (e_lat > 0) chk({tag, "_lat"}, cyc + 1, e_lat);
    if (e_wait >= 0) chk({tag, "_wait"}, cyc - (hs + 1), e_wait);
  endtask

  initial begin
    rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = '0;
    i_req_addr = '0; i_req_wdata = '0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_req_ready, 1'b1);
    chk("rst_memv", o_mem_valid, 1'b0);
    chk("rst_rspv", o_rsp_valid, 1'b0);
    chk("rst_maddr", o_mem_addr, 32'h0);
    chk("rst_mwm", o_mem_wmask, 32'h0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    rst_n = 1'b1;

    do_req("lb3",  1'b0, 3'b000, 32'd3,  32'h0, 32'hdeadbeef, 1, 32'hffffffde, 0, 1, 32'd0,  32'h0, 32'h0, 3, -1);
    do_req("sh10", 1'b1, 3'b001, 32'd10, 32'h0000b0ba, 32'h0, 0, 32'h0, 0, 1, 32'd8, 32'hb0ba0000, 32'hffff0000, 2, -1);
    do_req("lhu18", 1'b0, 3'b101, 32'd18, 32'h0, 32'hcafeb0ba, 1, 32'h0000cafe, 0, 1, 32'd16, 32'h0, 32'h0, 3, -1);
    do_req("lh18", 1'b0, 3'b001, 32'd18, 32'h0, 32'hcafeb0ba, 1, 32'hffffcafe, 0, 1, 32'd16, 32'h0, 32'h0, 3, -1);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw2",  1'b0, 3'b010, 32'd2,  32'h0, 32'h12345678, 1, 32'h0, 1, 0, 32'd0, 32'h0, 32'h0, 0, -1);
`else
    do_req("lw2",  1'b0, 3'b010, 32'd2,  32'h0, 32'h12345678, 1, 32'h12345678, 0, 1, 32'd0, 32'h0, 32'h0, 3, -1);
`endif
    do_req("sb5",  1'b1, 3'b000, 32'd5,  32'h123456a5, 32'h0, 0, 32'h0, 0, 1, 32'd4, 32'h0000a500, 32'h0000ff00, 2, -1);
    do_req("sw12", 1'b1, 3'b010, 32'd12, 32'h89abcdef, 32'h0, 0, 32'h0, 0, 1, 32'd12, 32'h89abcdef, 32'hffffffff, 2, -1);
    do_req("lbu1", 1'b0, 3'b100, 32'd1,  32'h0, 32'h00008000, 1, 32'h00000080, 0, 1, 32'd0, 32'h0, 32'h0, 3, -1);
    do_req("lb1",  1'b0, 3'b000, 32'd1,  32'h0, 32'h00008000, 1, 32'hffffff80, 0, 1, 32'd0, 32'h0, 32'h0, 3, -1);
    do_req("ld32", 1'b0, 3'b011, 32'd8,  32'h0, 32'h0, 1, 32'h0, 1, 0, 32'd0, 32'h0, 32'h0, 0, -1);
    do_req("lwu32", 1'b0, 3'b110, 32'd8, 32'h0, 32'h0, 1, 32'h0, 1, 0, 32'd0, 32'h0, 32'h0, 0, -1);
    do_req("ld_f7", 1'b0, 3'b111, 32'd8, 32'h0, 32'h0, 1, 32'h0, 1, 0, 32'd0, 32'h0, 32'h0, 0, -1);
    do_req("st_f4", 1'b1, 3'b100, 32'd8, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'd0, 32'h0, 32'h0, 0, -1);
    do_req("tmo",  1'b0, 3'b010, 32'd0,  32'h0, 32'h0, 0, 32'h0, 1, 1, 32'd0, 32'h0, 32'h0, 6, 4);

    // Stray memory strobes while idle must not produce a response.
    @(negedge clk);
    i_mem_rvalid = 1'b1; i_mem_ready = 1'b1; i_mem_rdata = 32'hffffffff;
    @(negedge clk);
    i_mem_rvalid = 1'b0; i_mem_ready = 1'b0;
    chk("idle_stray_ready", o_req_ready, 1'b1);

    // Reset while waiting for read data abandons the load.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'b010; i_req_addr = 32'd0;
    @(posedge clk); #1 i_req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_memv", o_mem_valid, 1'b1);
    i_mem_ready = 1'b1;
    @(posedge clk); #1 i_mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_ready", o_req_ready, 1'b1);
    chk("rstw_rspv", o_rsp_valid, 1'b0);
    chk("rstw_memv2", o_mem_valid, 1'b0);
    rst_n = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0badf00d;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    chk("rstw_late_ready", o_req_ready, 1'b1);
    do_req("lw_after_rst", 1'b0, 3'b010, 32'd4, 32'h0, 32'h5a5aa5a5, 1, 32'h5a5aa5a5, 0, 1, 32'd4, 32'h0, 32'h0, 3, -1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
